bitty_seq_ctrl: RTL
===================

Name: bitty_seq_ctrl

Overview:
- Program sequencer for the bitty core.
- Fetches 16-bit instructions from a word-addressed instruction memory over a req/ack handshake, and presents each one to bitty on d_instr with run held high.
- Waits for bitty's done, captures d_out as the instruction result, advances the PC, and stops on a halt opcode, program end, external halt or execution timeout.
- Sits between the instruction ROM/RAM and the bitty core top.

Parameters:
- ADDR_W, 8, PC / memory address width.
- DATA_W, 16, instruction and result width.
- HALT_INSTR, 16'hFFFF, opcode that terminates the program. It is not issued to bitty.
- TIMEOUT, 64, maximum cycles waiting for cpu_done before error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin execution at address 0
- halt_req  in  1  level: stop after the current instruction completes
- prog_len  in  ADDR_W  number of instructions (0 means 2^ADDR_W)
- mem_req  out  1  fetch request, held until mem_ack
- mem_addr  out  ADDR_W  fetch address, equals pc
- mem_ack  in  1  fetch data valid this cycle
- mem_rdata  in  DATA_W  fetched instruction
- cpu_run  out  1  drives bitty run
- cpu_instr  out  DATA_W  drives bitty d_instr
- cpu_done  in  1  bitty done
- cpu_dout  in  DATA_W  bitty d_out
- result  out  DATA_W  last captured cpu_dout
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high in any state except IDLE/FINISH/ERR
- finished  out  1  level: program completed normally
- error  out  1  level: timeout occurred
- pc  out  ADDR_W  current program counter
- instr_count  out  16  instructions retired since start; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs are 0: pc, instr_count, result, cpu_instr, mem_req, cpu_run, result_valid, finished, error.
  - Reset mid-operation aborts immediately with no write-back.
- FSM states: IDLE, FETCH, ISSUE, EXEC, WB, FINISH, ERR.
- IDLE / FINISH / ERR + start=1:
  - Clear pc, instr_count, finished, error.
  - Go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: if mem_rdata==HALT_INSTR go to FINISH; else latch cpu_instr<=mem_rdata and go to ISSUE.
  - mem_ack with no request pending is ignored.
- ISSUE:
  - cpu_run=1, cpu_instr stable, timeout counter cleared.
  - Go to EXEC next cycle. Latency is one cycle.
- EXEC:
  - cpu_run stays 1 and cpu_instr stays stable.
  - Timeout counter increments each cycle.
  - On cpu_done: result<=cpu_dout, go to WB. cpu_done is checked before the timeout, so done on the last allowed cycle counts as success.
  - Counter reaching TIMEOUT without done: go to ERR.
- WB:
  - cpu_run=0, result_valid=1 for exactly this cycle.
  - instr_count increments (saturating).
  - If pc==prog_len-1 (mod 2^ADDR_W) or halt_req=1: go to FINISH and hold pc.
  - Otherwise pc<=pc+1 (wraps modulo 2^ADDR_W) and go to FETCH.
- halt_req asserted during FETCH, ISSUE or EXEC does not abort. It is sampled only in WB.
- FINISH: finished=1 until next start.
- ERR: error=1, cpu_run=0, until next start.
- Minimum per-instruction latency with zero-wait memory and done on the first EXEC cycle: FETCH→ISSUE→EXEC→WB = 4 cycles.

Decomposition:
- Shared package bitty_pkg:
  - state enum encoding: IDLE=0, FETCH=1, ISSUE=2, EXEC=3, WB=4, FINISH=5, ERR=6
  - HALT_INSTR default
  - DATA_W
- One sub-module, bitty_timeout_ctr: clear/enable counter with terminal-count flag parameterised by TIMEOUT.
- The FSM and PC stay in the top.

Test Plan:
1. Three-instruction program (prog_len=3), zero-wait memory, done one cycle after run:
   - three result_valid pulses with results matching cpu_dout
   - instr_count=3, finished=1, pc=2, busy=0
2. Memory word 1 = 16'hFFFF, prog_len=8:
   - one instruction retires
   - HALT_INSTR never appears on cpu_instr
   - finished=1, pc=1, instr_count=1
3. cpu_done never asserted (TIMEOUT=64):
   - error=1 exactly 64 cycles after entering EXEC
   - cpu_run=0, no result_valid
   - subsequent start clears error and refetches address 0
4. halt_req raised during EXEC of instruction 0, prog_len=5:
   - instruction 0 completes, result_valid pulses once
   - finished=1, pc=0
5. reset pulled low mid-EXEC with cpu_run=1:
   - all outputs 0 asynchronously, state IDLE
   - start is ignored during reset and honoured after release
6. mem_ack delayed 5 cycles and start re-pulsed while busy:
   - mem_req and mem_addr held stable for the 5 cycles
   - re-start has no effect
   - prog_len=0 runs 256 instructions and pc wraps to 255 at finish

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty program sequencer: state encoding and
// default instruction/halt parameters.
package bitty_pkg;

  localparam int          BITTY_DATA_W     = 16;
  localparam logic [15:0] BITTY_HALT_INSTR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    FINISH = 3'd5,
    ERR    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/bitty_timeout_ctr.sv
// Execution watchdog: counts enabled cycles since the last clear and flags
// the final allowed waiting cycle.
module bitty_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // tc marks the TIMEOUT-th enabled cycle, so the caller can still accept a
  // completion arriving in that same cycle before declaring a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bitty_seq_ctrl.sv
// Program sequencer for the bitty core: fetches instructions, issues them on
// run/d_instr, waits for done, captures the result and advances the PC.
module bitty_seq_ctrl
  import bitty_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = BITTY_DATA_W,
  parameter logic [DATA_W-1:0] HALT_INSTR = BITTY_HALT_INSTR,
  parameter int                TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  output logic [DATA_W-1:0] cpu_instr,
  input  logic              cpu_done,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  seq_state_e        state;
  logic              exec_tc;
  logic [ADDR_W-1:0] last_pc;

  // prog_len of zero wraps to an all-ones last address, i.e. a full 2^ADDR_W program.
  assign last_pc  = prog_len - 1'b1;
  assign mem_addr = pc;
  assign busy     = (state == FETCH) || (state == ISSUE) ||
                    (state == EXEC)  || (state == WB);

  bitty_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ISSUE),
    .enable (state == EXEC),
    .tc     (exec_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= '0;
      instr_count  <= '0;
      result       <= '0;
      cpu_instr    <= '0;
      mem_req      <= 1'b0;
      cpu_run      <= 1'b0;
      result_valid <= 1'b0;
      finished     <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, FINISH, ERR: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            finished    <= 1'b0;
            error       <= 1'b0;
            mem_req     <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rdata == HALT_INSTR) begin
              finished <= 1'b1;
              state    <= FINISH;
            end else begin
              cpu_instr <= mem_rdata;
              cpu_run   <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= EXEC;
        end
        // Completion takes priority over the watchdog on the same cycle.
        EXEC: begin
          if (cpu_done) begin
            result       <= cpu_dout;
            result_valid <= 1'b1;
            cpu_run      <= 1'b0;
            state        <= WB;
          end else if (exec_tc) begin
            cpu_run <= 1'b0;
            error   <= 1'b1;
            state   <= ERR;
          end
        end
        WB: begin
          if (instr_count != 16'hFFFF) begin
            instr_count <= instr_count + 16'd1;
          end
          if ((pc == last_pc) || halt_req) begin
            finished <= 1'b1;
            state    <= FINISH;
          end else begin
            pc      <= pc + 1'b1;
            mem_req <= 1'b1;
            state   <= FETCH;
          end
        end
        default: begin
          cpu_run <= 1'b0;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
